api_tx_arbiter: RTL and testbench

API_TX_ARBITER -- requirements
Module: api_tx_arbiter

---
 rtl/api_tx_arbiter_pkg.sv | 32 +++
 rtl/api_tx_arbiter_rr_pick.sv | 29 ++
 rtl/api_tx_arbiter.sv | 122 ++++++++++++
 tb/tb_api_tx_arbiter.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/api_tx_arbiter_pkg.sv
// rtl/api_tx_arbiter_pkg.sv - shared API field widths, message layout and arbiter state encoding
package api_tx_arbiter_pkg;

  localparam int C_LENGTH_ADDR_SLOT = 4;
  localparam int C_LENGTH_ADDR_FPGA = 4;
  localparam int C_LENGTH_ADDR_REG  = 8;
  localparam int C_LENGTH_CMD       = 4;
  localparam int C_LENGTH_DATA      = 32;

  function automatic int f_msg_w(input int slot_w, input int fpga_w, input int reg_w,
                                 input int cmd_w, input int data_w);
    return slot_w + fpga_w + 2 * reg_w + 2 * cmd_w + data_w;
  endfunction

  localparam int C_MSG_W = f_msg_w(C_LENGTH_ADDR_SLOT, C_LENGTH_ADDR_FPGA, C_LENGTH_ADDR_REG,
                                   C_LENGTH_CMD, C_LENGTH_DATA);

  // Field offsets, data at the LSB end, tgt_slot at the MSB end
  localparam int C_OFF_DATA     = 0;
  localparam int C_OFF_SRC_CMD  = C_OFF_DATA + C_LENGTH_DATA;
  localparam int C_OFF_SRC_REG  = C_OFF_SRC_CMD + C_LENGTH_CMD;
  localparam int C_OFF_TGT_CMD  = C_OFF_SRC_REG + C_LENGTH_ADDR_REG;
  localparam int C_OFF_TGT_REG  = C_OFF_TGT_CMD + C_LENGTH_CMD;
  localparam int C_OFF_TGT_FPGA = C_OFF_TGT_REG + C_LENGTH_ADDR_REG;
  localparam int C_OFF_TGT_SLOT = C_OFF_TGT_FPGA + C_LENGTH_ADDR_FPGA;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } arb_state_t;

endpackage

// File: rtl/api_tx_arbiter_rr_pick.sv
// rtl/api_tx_arbiter_rr_pick.sv - combinational round-robin winner search starting at ptr+1
module api_rr_pick
  import api_tx_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] i_valid,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic [IDX_W-1:0]   o_winner,
  output logic               o_any
);

  int w_idx;

  always_comb begin
    o_winner = '0;
    o_any    = 1'b0;
    w_idx    = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_idx = (int'(i_ptr) + k) % NUM_REQ;
      if (!o_any && i_valid[w_idx]) begin
        o_winner = IDX_W'(w_idx);
        o_any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/api_tx_arbiter.sv
// rtl/api_tx_arbiter.sv - round-robin burst arbiter feeding the API output register port
module api_tx_arbiter
  import api_tx_arbiter_pkg::*;
#(
  parameter int NUM_REQ          = 4,
  parameter int MAX_BURST        = 8,
  parameter int LENGTH_ADDR_SLOT = C_LENGTH_ADDR_SLOT,
  parameter int LENGTH_ADDR_FPGA = C_LENGTH_ADDR_FPGA,
  parameter int LENGTH_ADDR_REG  = C_LENGTH_ADDR_REG,
  parameter int LENGTH_CMD       = C_LENGTH_CMD,
  parameter int LENGTH_DATA      = C_LENGTH_DATA,
  localparam int MSG_W = f_msg_w(LENGTH_ADDR_SLOT, LENGTH_ADDR_FPGA, LENGTH_ADDR_REG,
                                 LENGTH_CMD, LENGTH_DATA),
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                        clk_in,
  input  logic                        rst_n_in,
  input  logic [NUM_REQ-1:0]          req_valid_in,
  input  logic [NUM_REQ-1:0]          req_last_in,
  input  logic [NUM_REQ*MSG_W-1:0]    req_msg_in,
  output logic [NUM_REQ-1:0]          req_ready_out,
  input  logic                        o_rfd_in,
  output logic [LENGTH_ADDR_SLOT-1:0] o_tgt_slot_out,
  output logic [LENGTH_ADDR_FPGA-1:0] o_tgt_fpga_out,
  output logic [LENGTH_ADDR_REG-1:0]  o_tgt_reg_out,
  output logic [LENGTH_CMD-1:0]       o_tgt_cmd_out,
  output logic [LENGTH_ADDR_REG-1:0]  o_src_reg_out,
  output logic [LENGTH_CMD-1:0]       o_src_cmd_out,
  output logic [LENGTH_DATA-1:0]      o_data_out,
  output logic                        o_wr_en_out,
  output logic [IDX_W-1:0]            owner_out,
  output logic                        busy_out
);

  localparam int CNT_W    = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam int OFF_SCMD = LENGTH_DATA;
  localparam int OFF_SREG = OFF_SCMD + LENGTH_CMD;
  localparam int OFF_TCMD = OFF_SREG + LENGTH_ADDR_REG;
  localparam int OFF_TREG = OFF_TCMD + LENGTH_CMD;
  localparam int OFF_FPGA = OFF_TREG + LENGTH_ADDR_REG;
  localparam int OFF_SLOT = OFF_FPGA + LENGTH_ADDR_FPGA;

  arb_state_t       r_state;
  logic [IDX_W-1:0] r_ptr;
  logic [IDX_W-1:0] r_owner;
  logic [CNT_W-1:0] r_count;
  logic [MSG_W-1:0] r_msg;
  logic             r_wr_en;

  logic [IDX_W-1:0] w_winner;
  logic             w_any;
  logic             w_own_valid;
  logic             w_own_last;
  logic [MSG_W-1:0] w_own_msg;

  api_rr_pick #(.NUM_REQ(NUM_REQ)) u_rr_pick (
    .i_valid  (req_valid_in),
    .i_ptr    (r_ptr),
    .o_winner (w_winner),
    .o_any    (w_any)
  );

  assign w_own_valid = req_valid_in[r_owner];
  assign w_own_last  = req_last_in[r_owner];
  assign w_own_msg   = req_msg_in[r_owner*MSG_W +: MSG_W];

  // Only the owner may see ready, and only as a straight copy of o_rfd_in
  always_comb begin
    req_ready_out = '0;
    if (r_state == ST_BURST) req_ready_out[r_owner] = o_rfd_in;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state <= ST_IDLE;
      r_ptr   <= IDX_W'(NUM_REQ - 1);
      r_owner <= '0;
      r_count <= '0;
      r_msg   <= '0;
      r_wr_en <= 1'b0;
    end else begin
      r_wr_en <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_state <= ST_BURST;
            r_owner <= w_winner;
            r_count <= '0;
          end
        end
        ST_BURST: begin
          if (!w_own_valid) begin
            r_state <= ST_IDLE;
            r_ptr   <= r_owner;
          end else if (o_rfd_in) begin
            r_msg   <= w_own_msg;
            r_wr_en <= 1'b1;
            if (w_own_last || (r_count == CNT_W'(MAX_BURST - 1))) begin
              r_state <= ST_IDLE;
              r_ptr   <= r_owner;
            end else begin
              r_count <= r_count + CNT_W'(1);
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy_out       = (r_state == ST_BURST);
  assign owner_out      = r_owner;
  assign o_wr_en_out    = r_wr_en;
  assign o_data_out     = r_msg[LENGTH_DATA-1:0];
  assign o_src_cmd_out  = r_msg[OFF_SCMD +: LENGTH_CMD];
  assign o_src_reg_out  = r_msg[OFF_SREG +: LENGTH_ADDR_REG];
  assign o_tgt_cmd_out  = r_msg[OFF_TCMD +: LENGTH_CMD];
  assign o_tgt_reg_out  = r_msg[OFF_TREG +: LENGTH_ADDR_REG];
  assign o_tgt_fpga_out = r_msg[OFF_FPGA +: LENGTH_ADDR_FPGA];
  assign o_tgt_slot_out = r_msg[OFF_SLOT +: LENGTH_ADDR_SLOT];

endmodule

// File: tb/tb_api_tx_arbiter.sv
// tb/tb_api_tx_arbiter.sv - directed self-checking bench for api_tx_arbiter
module tb_api_tx_arbiter;
  import api_tx_arbiter_pkg::*;

  localparam int MSG_W = C_MSG_W;

  logic             clk_in = 1'b0;
  logic             rst_n_in = 1'b0;
  logic [3:0]       req_valid_in = '0;
  logic [3:0]       req_last_in = '0;
  logic [4*MSG_W-1:0] req_msg_in = '0;
  logic [3:0]       req_ready_out;
  logic             o_rfd_in = 1'b1;
  logic [3:0]       o_tgt_slot_out;
  logic [3:0]       o_tgt_fpga_out;
  logic [7:0]       o_tgt_reg_out;
  logic [3:0]       o_tgt_cmd_out;
  logic [7:0]       o_src_reg_out;
  logic [3:0]       o_src_cmd_out;
  logic [31:0]      o_data_out;
  logic             o_wr_en_out;
  logic [1:0]       owner_out;
  logic             busy_out;

  api_tx_arbiter dut (
    .clk_in         (clk_in),
    .rst_n_in       (rst_n_in),
    .req_valid_in   (req_valid_in),
    .req_last_in    (req_last_in),
    .req_msg_in     (req_msg_in),
    .req_ready_out  (req_ready_out),
    .o_rfd_in       (o_rfd_in),
    .o_tgt_slot_out (o_tgt_slot_out),
    .o_tgt_fpga_out (o_tgt_fpga_out),
    .o_tgt_reg_out  (o_tgt_reg_out),
    .o_tgt_cmd_out  (o_tgt_cmd_out),
    .o_src_reg_out  (o_src_reg_out),
    .o_src_cmd_out  (o_src_cmd_out),
    .o_data_out     (o_data_out),
    .o_wr_en_out    (o_wr_en_out),
    .owner_out      (owner_out),
    .busy_out       (busy_out)
  );

  always #5 clk_in = ~clk_in;

  int vectors = 0;
  int miscompares = 0;
  int rem[4], seq[4], blen[4], base[4];
  bit en[4];
  logic [31:0] wr_log[$];
  int grant_log[$];
  logic prev_busy;

  task automatic check_vec(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Requester model: beat n of requester i carries data base+n; last every blen beats (0 = never)
  task automatic drive();
    for (int i = 0; i < 4; i++) begin
      req_valid_in[i] = en[i] && (rem[i] > 0);
      req_last_in[i]  = (blen[i] != 0) && (((seq[i] + 1) % blen[i]) == 0);
      req_msg_in[i*MSG_W +: MSG_W] = {4'(i + 1), 4'(15 - i), 8'(16 + i), 4'(i),
                                      8'(32 + i), 4'(15 - i), 32'(base[i] + seq[i])};
    end
  endtask

  task automatic cycle();
    logic [3:0] x;
    x = req_valid_in & req_ready_out;
    if (o_wr_en_out) wr_log.push_back(o_data_out);
    if (busy_out && !prev_busy) grant_log.push_back(int'(owner_out));
    prev_busy = busy_out;
    @(posedge clk_in);
    #1;
    for (int i = 0; i < 4; i++)
      if (x[i]) begin
        seq[i]++;
        rem[i]--;
      end
    drive();
    #1;
  endtask

  task automatic run(input int n);
    for (int c = 0; c < n; c++) cycle();
  endtask

  task automatic do_reset();
    rst_n_in = 1'b0;
    o_rfd_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rem[i] = 0; seq[i] = 0; blen[i] = 0; base[i] = 0; en[i] = 1'b0;
    end
    drive();
    @(posedge clk_in);
    @(posedge clk_in);
    #1;
    rst_n_in = 1'b1;
    #1;
    wr_log.delete();
    grant_log.delete();
    prev_busy = 1'b0;
  endtask

  task automatic setup(input int i, input int r, input int bl, input int b);
    en[i] = 1'b1; rem[i] = r; blen[i] = bl; base[i] = b; seq[i] = 0;
  endtask

  initial begin
    // Reset state
    do_reset();
    check_vec("rst_ready", 64'(req_ready_out), 64'h0);
    check_vec("rst_busy", 64'(busy_out), 64'h0);
    check_vec("rst_wr_en", 64'(o_wr_en_out), 64'h0);
    check_vec("rst_owner", 64'(owner_out), 64'h0);
    check_vec("rst_data", 64'(o_data_out), 64'h0);

    // Single beat with 1-cycle arbitration and 1-cycle output latency
    setup(0, 1, 1, 'hA5);
    drive();
    #1;
    check_vec("sb_ready_idle", 64'(req_ready_out), 64'h0);
    cycle();
    check_vec("sb_ready", 64'(req_ready_out), 64'h1);
    check_vec("sb_busy", 64'(busy_out), 64'h1);
    check_vec("sb_wr_early", 64'(o_wr_en_out), 64'h0);
    cycle();
    check_vec("sb_wr_en", 64'(o_wr_en_out), 64'h1);
    check_vec("sb_data", 64'(o_data_out), 64'hA5);
    check_vec("sb_slot", 64'(o_tgt_slot_out), 64'h1);
    check_vec("sb_treg", 64'(o_tgt_reg_out), 64'h10);
    check_vec("sb_scmd", 64'(o_src_cmd_out), 64'hF);
    check_vec("sb_busy_after", 64'(busy_out), 64'h0);
    cycle();
    check_vec("sb_wr_once", 64'(o_wr_en_out), 64'h0);

    // Round-robin with single-beat bursts from all four
    do_reset();
    for (int i = 0; i < 4; i++) setup(i, 2, 1, i * 16);
    drive();
    run(24);
    check_vec("rr_grants", 64'(grant_log.size()), 64'd8);
    for (int g = 0; g < 5; g++) check_vec($sformatf("rr_owner%0d", g), 64'(grant_log[g]), 64'(g % 4));
    check_vec("rr_wr_count", 64'(wr_log.size()), 64'd8);
    check_vec("rr_wr4", 64'(wr_log[4]), 64'h01);
    check_vec("rr_wr7", 64'(wr_log[7]), 64'h31);

    // MAX_BURST cap: req2 never asserts last
    do_reset();
    setup(2, 20, 0, 'h200);
    drive();
    cycle();
    setup(1, 3, 0, 'h100);
    drive();
    #1;
    run(60);
    check_vec("cap_grants", 64'(grant_log.size()), 64'd4);
    check_vec("cap_g0", 64'(grant_log[0]), 64'd2);
    check_vec("cap_g1", 64'(grant_log[1]), 64'd1);
    check_vec("cap_g2", 64'(grant_log[2]), 64'd2);
    check_vec("cap_wr_count", 64'(wr_log.size()), 64'd23);
    check_vec("cap_wr7", 64'(wr_log[7]), 64'h207);
    check_vec("cap_wr8", 64'(wr_log[8]), 64'h100);
    check_vec("cap_wr11", 64'(wr_log[11]), 64'h208);
    check_vec("cap_wr22", 64'(wr_log[22]), 64'h213);

    // Back-pressure mid-burst; count must survive the stall
    do_reset();
    setup(0, 10, 0, 'h300);
    drive();
    run(3);
    o_rfd_in = 1'b0;
    #1;
    for (int s = 0; s < 5; s++) begin
      check_vec($sformatf("bp_ready%0d", s), 64'(req_ready_out), 64'h0);
      check_vec($sformatf("bp_busy%0d", s), 64'(busy_out), 64'h1);
      if (s > 0) check_vec($sformatf("bp_wr%0d", s), 64'(o_wr_en_out), 64'h0);
      cycle();
    end
    o_rfd_in = 1'b1;
    #1;
    run(30);
    check_vec("bp_grants", 64'(grant_log.size()), 64'd2);
    check_vec("bp_wr_count", 64'(wr_log.size()), 64'd10);
    for (int b = 0; b < 10; b++) check_vec($sformatf("bp_wr%0d_data", b), 64'(wr_log[b]), 64'('h300 + b));

    // Owner withdrawal after 3 beats
    do_reset();
    setup(0, 3, 0, 'h400);
    setup(1, 1, 1, 'h500);
    drive();
    run(20);
    check_vec("wd_grants", 64'(grant_log.size()), 64'd2);
    check_vec("wd_g0", 64'(grant_log[0]), 64'd0);
    check_vec("wd_g1", 64'(grant_log[1]), 64'd1);
    check_vec("wd_wr_count", 64'(wr_log.size()), 64'd4);
    check_vec("wd_wr2", 64'(wr_log[2]), 64'h402);
    check_vec("wd_wr3", 64'(wr_log[3]), 64'h500);

    // Asynchronous reset mid-burst
    do_reset();
    setup(0, 5, 0, 'h655);
    drive();
    run(2);
    check_vec("ar_pre_busy", 64'(busy_out), 64'h1);
    check_vec("ar_pre_data", 64'(o_data_out), 64'h655);
    rst_n_in = 1'b0;
    #1;
    check_vec("ar_busy", 64'(busy_out), 64'h0);
    check_vec("ar_ready", 64'(req_ready_out), 64'h0);
    check_vec("ar_wr_en", 64'(o_wr_en_out), 64'h0);
    check_vec("ar_owner", 64'(owner_out), 64'h0);
    check_vec("ar_data", 64'(o_data_out), 64'h0);
    @(posedge clk_in);
    #1;
    rst_n_in = 1'b1;
    #1;
    check_vec("ar_idle_after", 64'(busy_out), 64'h0);
    check_vec("ar_no_wr_after", 64'(o_wr_en_out), 64'h0);
    cycle();
    check_vec("ar_regrant", 64'(busy_out), 64'h1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
